lock_code_checker: RTL and testbench

Sequential code-entry checker for the digital security system. It accepts BCD digits from the keypad one per strobe and compares each digit against the stored code as it arrives. On confirm it either opens the lock or counts a failed attempt, and it enforces an alarmed lockout after repeated failures. While open, it can store a new code. It sits between the keypad decoder and the lock/alarm drivers.

---
 rtl/lock_pkg.sv | 23 ++
 rtl/digit_cmp.sv | 16 +
 rtl/lock_code_checker.sv | 167 ++++++++++++++++
 tb/tb_lock_code_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code checker.
// Stored code reset value, digit type and FSM state encoding.
package lock_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } state_e;

  localparam int DEFAULT_LEN = 4;

  // Element 0 is the first digit keyed in.
  localparam digit_t [DEFAULT_LEN-1:0] DEFAULT_CODE = {4'd4, 4'd3, 4'd2, 4'd1};

  localparam digit_t MAX_DIGIT = 4'd9;

endpackage

// File: rtl/digit_cmp.sv
// Combinational 4-bit magnitude comparator, zero latency, no flow control.
module digit_cmp
  import lock_pkg::*;
(
  input  digit_t a_i,
  input  digit_t b_i,
  output logic   eq_o,
  output logic   lt_o,
  output logic   gt_o
);

  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/lock_code_checker.sv
// Keypad code checker: per-digit compare, open window, failure count and alarmed lockout.
// Outputs registered; unlock two edges after enter, alarm three; keys ignored in lockout.
module lock_code_checker
  import lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         key_valid,
  input  logic [3:0]                   key_digit,
  input  logic                         key_enter,
  output logic                         unlocked,
  output logic                         alarm,
  output logic [1:0]                   tries,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

  localparam int CW   = $clog2(DIGITS + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] FULL      = CW'(DIGITS);
  localparam logic [1:0]    TRIES_MAX = 2'(MAX_TRIES);

  state_e              state_q, state_d;
  digit_t [DIGITS-1:0] code_q, code_d;
  digit_t [DIGITS-1:0] new_code_q, new_code_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mismatch_q, mismatch_d;
  logic [1:0]          tries_q, tries_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                unlocked_q, unlocked_d;
  logic                alarm_q, alarm_d;

  logic       code_eq, code_lt_unused, code_gt_unused;
  logic       digit_gt_max, max_eq_unused, max_lt_unused;
  logic       digit_acc;
  logic       timer_zero;
  logic [1:0] tries_inc;

  digit_cmp u_cmp_code (
    .a_i  (key_digit),
    .b_i  (code_q[cnt_q[IW-1:0]]),
    .eq_o (code_eq),
    .lt_o (code_lt_unused),
    .gt_o (code_gt_unused)
  );

  digit_cmp u_cmp_max (
    .a_i  (key_digit),
    .b_i  (MAX_DIGIT),
    .eq_o (max_eq_unused),
    .lt_o (max_lt_unused),
    .gt_o (digit_gt_max)
  );

  // Enter takes priority over a simultaneous digit strobe.
  assign digit_acc  = key_valid && !key_enter && !digit_gt_max && (cnt_q < FULL);
  assign timer_zero = (timer_q == '0);
  assign tries_inc  = tries_q + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (key_enter) state_d = ST_FAIL;
                  else if (digit_acc) state_d = ST_ENTRY;
      ST_ENTRY:   if (key_enter) state_d = ST_CHECK;
      ST_CHECK:   state_d = ((cnt_q == FULL) && !mismatch_q) ? ST_OPEN : ST_FAIL;
      ST_OPEN:    if (key_enter && (cnt_q == FULL)) state_d = ST_IDLE;
                  else if (!digit_acc && timer_zero) state_d = ST_IDLE;
      ST_FAIL:    state_d = (tries_inc == TRIES_MAX) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (timer_zero) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    unlocked_d = (state_q == ST_OPEN);
    alarm_d    = (state_q == ST_LOCKOUT);
  end

  always_comb begin
    code_d     = code_q;
    new_code_d = new_code_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    tries_d    = tries_q;
    timer_d    = timer_zero ? timer_q : timer_q - TW'(1);
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (digit_acc) begin
          cnt_d      = cnt_q + CW'(1);
          mismatch_d = mismatch_q | ~code_eq;
        end
      end
      ST_CHECK: begin
        cnt_d      = '0;
        mismatch_d = 1'b0;
        if (state_d == ST_OPEN) begin
          tries_d = 2'd0;
          timer_d = OPEN_LOAD;
        end
      end
      ST_OPEN: begin
        if (key_enter) begin
          cnt_d = '0;
          if (cnt_q == FULL) code_d = new_code_q;
        end else if (digit_acc) begin
          new_code_d[cnt_q[IW-1:0]] = key_digit;
          cnt_d   = cnt_q + CW'(1);
          timer_d = OPEN_LOAD;
        end else if (timer_zero) begin
          cnt_d = '0;
        end
      end
      ST_FAIL: begin
        tries_d = tries_inc;
        if (state_d == ST_LOCKOUT) timer_d = LOCK_LOAD;
      end
      ST_LOCKOUT: if (timer_zero) tries_d = 2'd0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q     <= DEFAULT_CODE;
      new_code_q <= '0;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      tries_q    <= 2'd0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      code_q     <= code_d;
      new_code_q <= new_code_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign unlocked  = unlocked_q;
  assign alarm     = alarm_q;
  assign tries     = tries_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_lock_code_checker.sv
// Directed bench for lock_code_checker: code entry, failures, lockout, code change, reset.
`timescale 1ns/1ps
module tb_lock_code_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic       unlocked;
  logic       alarm;
  logic [1:0] tries;
  logic [2:0] digit_cnt;

  int checks = 0;
  int errors = 0;

  lock_code_checker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .key_enter (key_enter),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .tries     (tries),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  // Keys four digits, confirms, and returns just after edge N+2.
  task automatic try_code(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
    enter();
    ticks(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    key_enter = 1'b0;
    ticks(2);
    chk("rst_unlocked", unlocked, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_tries", tries, 0);
    chk("rst_digit_cnt", digit_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Correct code: unlock at N+2, held exactly 8 cycles.
    press(1); press(2); press(3); press(4);
    chk("t1_cnt4", digit_cnt, 4);
    enter();
    chk("t1_n0_unl", unlocked, 0);
    tick();
    chk("t1_n1_unl", unlocked, 0);
    tick();
    chk("t1_n2_unl", unlocked, 1);
    chk("t1_tries", tries, 0);
    ticks(7);
    chk("t1_n9_unl", unlocked, 1);
    tick();
    chk("t1_n10_unl", unlocked, 0);

    // Three wrong codes lead to a 16-cycle alarm with keys ignored.
    try_code(1, 2, 3, 5);
    chk("t2_tries1", tries, 1);
    chk("t2_unl1", unlocked, 0);
    try_code(1, 2, 3, 5);
    chk("t2_tries2", tries, 2);
    try_code(1, 2, 3, 5);
    chk("t2_tries3", tries, 3);
    chk("t2_n2_alarm", alarm, 0);
    tick();
    chk("t2_n3_alarm", alarm, 1);
    press(1); press(2); press(3); press(4);
    enter();
    chk("t2_lock_cnt", digit_cnt, 0);
    chk("t2_lock_alarm", alarm, 1);
    ticks(9);
    chk("t2_n17_alarm", alarm, 1);
    chk("t2_n17_tries", tries, 3);
    tick();
    chk("t2_n18_alarm", alarm, 1);
    chk("t2_n18_tries", tries, 0);
    tick();
    chk("t2_n19_alarm", alarm, 0);
    chk("t2_lock_unl", unlocked, 0);

    // Short entry fails; out-of-range digit is ignored.
    press(1); press(2); press(3);
    enter();
    ticks(2);
    chk("t3_short_tries", tries, 1);
    chk("t3_short_unl", unlocked, 0);
    press(1);
    press(12);
    chk("t3_cnt_skip12", digit_cnt, 1);
    press(2); press(3); press(4);
    enter();
    ticks(2);
    chk("t3_open", unlocked, 1);
    chk("t3_tries0", tries, 0);

    // New code 9,8,7,6 stored while open.
    press(9); press(8); press(7); press(6);
    chk("t4_new_cnt", digit_cnt, 4);
    enter();
    chk("t4_commit_cnt", digit_cnt, 0);
    tick();
    chk("t4_closed", unlocked, 0);
    try_code(1, 2, 3, 4);
    chk("t4_old_fails", tries, 1);
    chk("t4_old_unl", unlocked, 0);
    try_code(9, 8, 7, 6);
    chk("t4_new_opens", unlocked, 1);
    chk("t4_new_tries", tries, 0);

    // A digit at N+8 reloads the open timer: unlock now falls at N+17.
    ticks(5);
    press(0);
    chk("t4_reload_cnt", digit_cnt, 1);
    ticks(8);
    chk("t4_n16_unl", unlocked, 1);
    tick();
    chk("t4_n17_unl", unlocked, 0);
    chk("t4_expire_cnt", digit_cnt, 0);

    // Reset while open drops the lock and restores the default code.
    try_code(9, 8, 7, 6);
    chk("t6_open_pre", unlocked, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_open_rst_unl", unlocked, 0);
    tick();
    reset_n = 1'b1;
    tick();
    try_code(1, 2, 3, 4);
    chk("t6_default_back", unlocked, 1);
    ticks(8);
    chk("t6_closed", unlocked, 0);

    // Bare enter counts as a failure; reset during lockout clears the alarm.
    enter();
    ticks(2);
    chk("t6_bare_enter", tries, 1);
    try_code(1, 2, 3, 5);
    try_code(1, 2, 3, 5);
    tick();
    chk("t6_lock_pre", alarm, 1);
    ticks(3);
    reset_n = 1'b0;
    #1;
    chk("t6_lock_rst_alarm", alarm, 0);
    chk("t6_lock_rst_tries", tries, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Digit together with enter is discarded.
    press(1); press(2); press(3);
    key_valid = 1'b1;
    key_digit = 4'd4;
    key_enter = 1'b1;
    tick();
    key_valid = 1'b0;
    key_digit = 4'd0;
    key_enter = 1'b0;
    chk("t5_cnt_kept", digit_cnt, 3);
    ticks(2);
    chk("t5_fail_tries", tries, 1);
    chk("t5_fail_unl", unlocked, 0);

    // A fifth digit is ignored and the entry still opens.
    press(1); press(2); press(3); press(4); press(5);
    chk("t7_cnt_cap", digit_cnt, 4);
    enter();
    ticks(2);
    chk("t7_open", unlocked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
